// File: rtl/obi_bus_matrix_pkg.sv
// Shared OBI bus types and constants for the bus matrix.
package obi_bus_matrix_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

  typedef struct packed {
    logic [31:0] idx;
    logic [31:0] start_addr;
    logic [31:0] end_addr;
  } addr_map_rule_t;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hBADACCE5;

  // Index width that stays at least one bit for single-entry sets.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/obi_bus_matrix_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, pointer moves past the winner on ack.
module obi_rr_arbiter
  import obi_bus_matrix_pkg::*;
#(
  parameter int unsigned N  = 5,
  localparam int unsigned PW = clog2_min1(N)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [N-1:0]  i_req,
  input  logic          i_ack,
  output logic [N-1:0]  o_gnt,
  output logic [PW-1:0] o_idx
);

  logic [PW-1:0] r_ptr;
  logic [PW:0]   w_sum;
  logic          w_found;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_sum   = '0;
    for (int i = 0; i < N; i++) begin
      w_sum = {1'b0, r_ptr} + (PW+1)'(i);
      if (w_sum >= (PW+1)'(N)) w_sum = w_sum - (PW+1)'(N);
      if (!w_found && i_req[w_sum[PW-1:0]]) begin
        w_found              = 1'b1;
        o_gnt[w_sum[PW-1:0]] = 1'b1;
        o_idx                = w_sum[PW-1:0];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)      r_ptr <= '0;
    else if (i_ack) r_ptr <= (o_idx == PW'(N-1)) ? '0 : o_idx + PW'(1);
  end

endmodule

// File: rtl/obi_bus_matrix.sv
// OBI crossbar: address decode, per-target round-robin, in-order response
// routing through per-target route FIFOs, and an internal error responder.
module obi_bus_matrix
  import obi_bus_matrix_pkg::*;
#(
  parameter int unsigned NMASTER   = 5,
  parameter int unsigned NSLAVE    = 4,
  parameter int unsigned MAX_OUT   = 2,
  parameter logic [31:0] ERR_RDATA = ERR_RDATA_DEFAULT
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  addr_map_rule_t [NSLAVE-1:0]   addr_map_i,
  input  obi_req_t       [NMASTER-1:0]  master_req_i,
  output obi_resp_t      [NMASTER-1:0]  master_resp_o,
  output obi_req_t       [NSLAVE-1:0]   slave_req_o,
  input  obi_resp_t      [NSLAVE-1:0]   slave_resp_i,
  output logic           [15:0]         err_cnt_o,
  output logic           [31:0]         err_addr_o,
  output logic                          proto_err_o
);

  localparam int unsigned NT = NSLAVE + 1;
  localparam int unsigned MW = clog2_min1(NMASTER);
  localparam int unsigned TW = clog2_min1(NT);
  localparam int unsigned CW = $clog2(MAX_OUT + 1);

  logic [NMASTER-1:0][TW-1:0]            w_tgt;
  logic [NMASTER-1:0]                    w_elig;
  logic [NMASTER-1:0][CW-1:0]            r_out;
  logic [NMASTER-1:0][TW-1:0]            r_last;
  logic [NT-1:0][NMASTER-1:0]            w_areq, w_win;
  logic [NT-1:0]                         w_tgnt, w_hs, w_pop;
  logic [NT-1:0][MW-1:0]                 w_wid;
  logic [NT-1:0][31:0]                   w_rdata;
  logic [NT-1:0][MAX_OUT-1:0][MW-1:0]    r_fifo, w_fifo_nx;
  logic [NT-1:0][CW-1:0]                 r_fcnt, w_fcnt_nx;
  logic [31:0]                           w_err_addr;
  logic                                  w_perr;
  logic [15:0]                           r_err_cnt;
  logic [31:0]                           r_err_addr;
  logic                                  r_perr;

  // Decode walks rules high to low so the lowest matching rule wins.
  always_comb begin
    for (int m = 0; m < NMASTER; m++) begin
      w_tgt[m] = TW'(NSLAVE);
      for (int r = int'(NSLAVE) - 1; r >= 0; r--) begin
        if (master_req_i[m].addr >= addr_map_i[r].start_addr &&
            master_req_i[m].addr <  addr_map_i[r].end_addr)
          w_tgt[m] = (addr_map_i[r].idx < NSLAVE) ? TW'(addr_map_i[r].idx) : TW'(NSLAVE);
      end
      w_elig[m] = master_req_i[m].req && (r_out[m] < CW'(MAX_OUT)) &&
                  ((r_out[m] == '0) || (w_tgt[m] == r_last[m]));
    end
  end

  always_comb begin
    for (int t = 0; t < NT; t++)
      for (int m = 0; m < NMASTER; m++)
        w_areq[t][m] = w_elig[m] && (w_tgt[m] == TW'(t)) && (r_fcnt[t] < CW'(MAX_OUT));
  end

  for (genvar t = 0; t < NT; t++) begin : g_tgt
    obi_rr_arbiter #(.N(NMASTER)) u_arb (
      .i_clk (clk_i),
      .i_rst (rst_i),
      .i_req (w_areq[t]),
      .i_ack (w_hs[t]),
      .o_gnt (w_win[t]),
      .o_idx (w_wid[t])
    );
    assign w_hs[t] = (|w_win[t]) && w_tgnt[t];

    if (t < NSLAVE) begin : g_slv
      assign w_tgnt[t]  = slave_resp_i[t].gnt;
      assign w_pop[t]   = slave_resp_i[t].rvalid && (r_fcnt[t] != '0);
      assign w_rdata[t] = slave_resp_i[t].rdata;
      always_comb begin
        slave_req_o[t] = '0;
        for (int m = 0; m < NMASTER; m++)
          if (w_win[t][m]) slave_req_o[t] = master_req_i[m];
      end
    end else begin : g_err
      // Error responder answers its FIFO head every cycle it is non-empty.
      assign w_tgnt[t]  = 1'b1;
      assign w_pop[t]   = (r_fcnt[t] != '0);
      assign w_rdata[t] = ERR_RDATA;
      always_comb begin
        w_err_addr = '0;
        for (int m = 0; m < NMASTER; m++)
          if (w_win[t][m]) w_err_addr = master_req_i[m].addr;
      end
    end
  end

  always_comb begin
    w_perr = 1'b0;
    for (int t = 0; t < NSLAVE; t++)
      if (slave_resp_i[t].rvalid && (r_fcnt[t] == '0)) w_perr = 1'b1;
  end

  // Shift-down route FIFO; a push lands after any same-cycle pop.
  always_comb begin
    w_fifo_nx = r_fifo;
    w_fcnt_nx = r_fcnt;
    for (int t = 0; t < NT; t++) begin
      if (w_pop[t]) begin
        for (int k = 0; k < int'(MAX_OUT) - 1; k++) w_fifo_nx[t][k] = r_fifo[t][k+1];
        w_fcnt_nx[t] = r_fcnt[t] - CW'(1);
      end
      if (w_hs[t]) begin
        for (int k = 0; k < MAX_OUT; k++)
          if (CW'(k) == w_fcnt_nx[t]) w_fifo_nx[t][k] = w_wid[t];
        w_fcnt_nx[t] = w_fcnt_nx[t] + CW'(1);
      end
    end
  end

  always_comb begin
    for (int m = 0; m < NMASTER; m++) begin
      master_resp_o[m] = '0;
      for (int t = 0; t < NT; t++) begin
        if (w_win[t][m] && w_tgnt[t]) master_resp_o[m].gnt = 1'b1;
        if (w_pop[t] && (r_fifo[t][0] == MW'(m))) begin
          master_resp_o[m].rvalid = 1'b1;
          master_resp_o[m].rdata  = w_rdata[t];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_fifo <= '0;
      r_fcnt <= '0;
    end else begin
      r_fifo <= w_fifo_nx;
      r_fcnt <= w_fcnt_nx;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_out  <= '0;
      r_last <= '0;
    end else begin
      for (int m = 0; m < NMASTER; m++) begin
        if (master_resp_o[m].gnt && !master_resp_o[m].rvalid)      r_out[m] <= r_out[m] + CW'(1);
        else if (!master_resp_o[m].gnt && master_resp_o[m].rvalid) r_out[m] <= r_out[m] - CW'(1);
        if (master_resp_o[m].gnt) r_last[m] <= w_tgt[m];
      end
    end
  end

  // A zero count means no error has been seen yet, since the count saturates.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_err_cnt  <= '0;
      r_err_addr <= '0;
      r_perr     <= 1'b0;
    end else begin
      if (w_hs[NSLAVE]) begin
        if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
        if (r_err_cnt == 16'h0000) r_err_addr <= w_err_addr;
      end
      if (w_perr) r_perr <= 1'b1;
    end
  end

  assign err_cnt_o   = r_err_cnt;
  assign err_addr_o  = r_err_addr;
  assign proto_err_o = r_perr;

endmodule
